// File: rtl/sha256_block_sequencer_if.sv
// Block/digest stream and round-stage port of the SHA-256 block sequencer.
// The midstate signals exist only when SHA256_MIDSTATE_EN is defined.
interface sha256_block_sequencer_if;
  logic [511:0]      block;
  logic              blockFirst;
  logic              blockValid;
  logic              blockReady;
  logic [255:0]      digest;
  logic              digestValid;
  logic              digestReady;
  logic [31:0]       roundK;
  logic [15:0][31:0] roundW;
  logic [7:0][31:0]  roundVars;
  logic [15:0][31:0] roundWOut;
  logic [7:0][31:0]  roundVarsOut;
`ifdef SHA256_MIDSTATE_EN
  logic [255:0]      midstate;
  logic              blockMidstate;

  modport master (
    input  block, blockFirst, blockValid, digestReady, roundWOut, roundVarsOut,
    input  midstate, blockMidstate,
    output blockReady, digest, digestValid, roundK, roundW, roundVars
  );
  modport slave (
    output block, blockFirst, blockValid, digestReady, roundWOut, roundVarsOut,
    output midstate, blockMidstate,
    input  blockReady, digest, digestValid, roundK, roundW, roundVars
  );
`else
  modport master (
    input  block, blockFirst, blockValid, digestReady, roundWOut, roundVarsOut,
    output blockReady, digest, digestValid, roundK, roundW, roundVars
  );
  modport slave (
    output block, blockFirst, blockValid, digestReady, roundWOut, roundVarsOut,
    input  blockReady, digest, digestValid, roundK, roundW, roundVars
  );
`endif
endinterface

// File: rtl/sha256_block_sequencer.sv
// Iterative SHA-256 block sequencer: drives an external one-round stage for 64 cycles
// and applies the chaining add. Optional SHA256_MIDSTATE_EN adds an external H load.
module sha256_block_sequencer (
  input  logic                      clk,
  input  logic                      rstN,
  sha256_block_sequencer_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  state_t            state, stateNxt;
  logic [5:0]        idx;
  logic [15:0][31:0] wReg;   // wReg[0] = W0
  logic [7:0][31:0]  hReg;   // hReg[0] = H0 = a
  logic              accept;

  assign accept = bus.blockValid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept)          stateNxt = ROUND;
      ROUND:   if (idx == 6'd63)    stateNxt = FINAL;
      FINAL:                        stateNxt = DONE;
      DONE:    if (bus.digestReady) stateNxt = IDLE;
      default:                      stateNxt = IDLE;
    endcase
  end

  // Round 0 is seeded from the latched block and H; later rounds feed the stage back to itself.
  always_comb begin
    bus.blockReady  = (state == IDLE);
    bus.digestValid = (state == DONE);
    bus.roundK      = K[idx];
    if (idx == 6'd0) begin
      bus.roundW    = wReg;
      bus.roundVars = hReg;
    end else begin
      bus.roundW    = bus.roundWOut;
      bus.roundVars = bus.roundVarsOut;
    end
    bus.digest = '0;
    for (int i = 0; i < 8; i++) bus.digest[255-32*i -: 32] = hReg[i];
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      idx  <= '0;
      wReg <= '0;
      hReg <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          idx <= '0;
          for (int i = 0; i < 16; i++) wReg[i] <= bus.block[511-32*i -: 32];
`ifdef SHA256_MIDSTATE_EN
          if (bus.blockMidstate) begin
            for (int i = 0; i < 8; i++) hReg[i] <= bus.midstate[255-32*i -: 32];
          end else if (bus.blockFirst) begin
            for (int i = 0; i < 8; i++) hReg[i] <= IV[i];
          end
`else
          if (bus.blockFirst) begin
            for (int i = 0; i < 8; i++) hReg[i] <= IV[i];
          end
`endif
        end
        ROUND: idx <= idx + 6'd1;
        FINAL: for (int i = 0; i < 8; i++) hReg[i] <= hReg[i] + bus.roundVarsOut[i];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench: behavioural round stage, reference compression model and digest scoreboard.
module tb_sha256_block_sequencer;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  sha256_block_sequencer_if bus();
  sha256_block_sequencer dut (.clk(clk), .rstN(rstN), .bus(bus));

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO0  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO1  = {480'h0, 32'h000001c0};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [255:0] expQ [$];
  int           latQ [$];
  logic [255:0] lastDigest = '0;
  logic         prevValid  = 1'b0;
  logic [7:0][31:0] mH = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3); endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  function automatic logic [7:0][31:0] roundFn(input logic [7:0][31:0] v, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    logic [7:0][31:0] r;
    t1 = v[7] + bs1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = bs0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    r[7] = v[6]; r[6] = v[5]; r[5] = v[4]; r[4] = v[3] + t1;
    r[3] = v[2]; r[2] = v[1]; r[1] = v[0]; r[0] = t1 + t2;
    return r;
  endfunction

  function automatic logic [15:0][31:0] nextW(input logic [15:0][31:0] w);
    logic [15:0][31:0] r;
    for (int i = 0; i < 15; i++) r[i] = w[i+1];
    r[15] = ss1(w[14]) + w[9] + ss0(w[1]) + w[0];
    return r;
  endfunction

  function automatic logic [7:0][31:0] refCompress(input logic [7:0][31:0] h, input logic [511:0] b);
    logic [15:0][31:0] w;
    logic [7:0][31:0] v, r;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    v = h;
    for (int t = 0; t < 64; t++) begin
      v = roundFn(v, KT[t], w[0]);
      w = nextW(w);
    end
    for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] pack(input logic [7:0][31:0] h);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[255-32*i -: 32] = h[i];
    return d;
  endfunction

  // Behavioural one-round stage with a single registered cycle of latency.
  always @(posedge clk) begin
    bus.roundVarsOut <= roundFn(bus.roundVars, bus.roundK, bus.roundW[0]);
    bus.roundWOut    <= nextW(bus.roundW);
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstN && bus.digestValid && !prevValid) begin
      chk("latPending", 256'(latQ.size() > 0), 256'd1);
      if (latQ.size() > 0) chk("latency", 256'(cyc - latQ.pop_front()), 256'd66);
    end
    if (rstN && bus.digestValid && bus.digestReady) begin
      chk("expPending", 256'(expQ.size() > 0), 256'd1);
      if (expQ.size() > 0) chk("digest", bus.digest, expQ.pop_front());
      lastDigest = bus.digest;
    end
    prevValid = rstN && bus.digestValid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBlock(input logic [511:0] b, input logic first, input logic ms);
    int n;
    n = 0;
    while (!bus.blockReady && n < 300) begin tick(1); n++; end
    chk("readyWait", 256'(bus.blockReady), 256'd1);
    bus.block      = b;
    bus.blockFirst = first;
    bus.blockValid = 1'b1;
`ifdef SHA256_MIDSTATE_EN
    bus.blockMidstate = ms;
    bus.midstate      = pack(mHiv());
`endif
    tick(1);
    bus.blockValid = 1'b0;
    if (ms) mH = mHiv();
    else if (first) mH = mHiv();
    mH = refCompress(mH, b);
    expQ.push_back(pack(mH));
    latQ.push_back(cyc - 1);
  endtask

  function automatic logic [7:0][31:0] mHiv();
    logic [7:0][31:0] h;
    for (int i = 0; i < 8; i++) h[i] = IVT[i];
    return h;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 2000) begin tick(1); n++; end
    chk("drain", 256'(expQ.size()), 256'd0);
    tick(1);
  endtask

  task automatic resetAll();
    rstN = 1'b0;
    tick(1);
    rstN = 1'b1;
    expQ.delete();
    latQ.delete();
    mH = '0;
  endtask

  initial begin
    logic [511:0] rb;
    logic [255:0] d0;
    int n;
    bus.block = '0; bus.blockFirst = 1'b0; bus.blockValid = 1'b0; bus.digestReady = 1'b1;
`ifdef SHA256_MIDSTATE_EN
    bus.midstate = '0; bus.blockMidstate = 1'b0;
`endif
    tick(3);
    rstN = 1'b1;
    chk("rstValid", 256'(bus.digestValid), 256'd0);
    chk("rstDigest", bus.digest, 256'd0);
    chk("rstReady", 256'(bus.blockReady), 256'd1);

    sendBlock(BLK_ABC, 1'b1, 1'b0);
    chk("busyReady", 256'(bus.blockReady), 256'd0);
    drain();
    chk("abcKnown", lastDigest, ABC);

    sendBlock(BLK_EMPTY, 1'b1, 1'b0);
    drain();
    chk("emptyKnown", lastDigest, EMPTY);

    sendBlock(BLK_TWO0, 1'b1, 1'b0);
    sendBlock(BLK_TWO1, 1'b0, 1'b0);
    drain();
    chk("twoBlockKnown", lastDigest, TWO);

    // blockFirst=0 straight after reset chains from H=0
    resetAll();
    sendBlock(BLK_ABC, 1'b0, 1'b0);
    drain();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) rb[511-32*i -: 32] = $urandom();
      sendBlock(rb, 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();

    // Backpressure: digest held stable while the consumer stalls
    bus.digestReady = 1'b0;
    sendBlock(BLK_ABC, 1'b1, 1'b0);
    n = 0;
    while (!bus.digestValid && n < 200) begin tick(1); n++; end
    chk("bpValidSeen", 256'(bus.digestValid), 256'd1);
    d0 = bus.digest;
    chk("bpDigest", d0, ABC);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bpStable", bus.digest, d0);
      chk("bpReadyLow", 256'(bus.blockReady), 256'd0);
      chk("bpValidHeld", 256'(bus.digestValid), 256'd1);
    end
    bus.digestReady = 1'b1;
    tick(1);
    chk("bpReadyAfter", 256'(bus.blockReady), 256'd1);
    drain();

    // Reset while idx=30
    sendBlock(BLK_ABC, 1'b1, 1'b0);
    tick(30);
    resetAll();
    chk("midRstValid", 256'(bus.digestValid), 256'd0);
    chk("midRstReady", 256'(bus.blockReady), 256'd1);
    chk("midRstDigest", bus.digest, 256'd0);
    sendBlock(BLK_ABC, 1'b1, 1'b0);
    drain();
    chk("abcAfterRst", lastDigest, ABC);

`ifdef SHA256_MIDSTATE_EN
    sendBlock(BLK_EMPTY, 1'b1, 1'b0);
    drain();
    sendBlock(BLK_ABC, 1'b0, 1'b1);
    drain();
    chk("midstateAbc", lastDigest, ABC);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
